// File: rtl/regfile_write_decoder.sv
// Write-side register file: one-stage request register, one-hot address decode, 32-word storage
// exposed bit-sliced for 32:1 read muxes. Optional byte-mask writes via REGFILE_BYTE_MASK_EN.
module regfile_write_decoder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    localparam int NUM_REGS  = 2 ** ADDR_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
`ifdef REGFILE_BYTE_MASK_EN
    input  logic [DATA_WIDTH/8-1:0]        wr_be,
`endif
    output logic [NUM_REGS-1:0]            dec_onehot,
    output logic                           pend_valid,
    output logic [ADDR_WIDTH-1:0]          pend_addr,
    output logic [DATA_WIDTH-1:0]          pend_data,
    output logic                           wr_ack,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_sliced,
    output logic [15:0]                    commit_count
);

    logic                  s1_req;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_live;
    logic [DATA_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

`ifdef REGFILE_BYTE_MASK_EN
    logic [DATA_WIDTH/8-1:0] s1_be;
`endif

    // Address is only sampled when a request is valid, so X on an idle bus never reaches state.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_req  <= 1'b0;
            s1_addr <= '0;
            s1_data <= '0;
`ifdef REGFILE_BYTE_MASK_EN
            s1_be   <= '0;
`endif
        end else begin
            s1_req <= wr_en;
            if (wr_en) begin
                s1_addr <= wr_addr;
                s1_data <= wr_data;
`ifdef REGFILE_BYTE_MASK_EN
                s1_be   <= wr_be;
`endif
            end
        end
    end

`ifdef REGFILE_BYTE_MASK_EN
    always_comb begin
        s1_live = s1_req && (s1_be != '0)
                  && !((ZERO_REG != 0) && (s1_addr == '0));
        wmask = '0;
        for (int k = 0; k < DATA_WIDTH/8; k++) begin
            wmask[k*8 +: 8] = {8{s1_be[k]}};
        end
    end
`else
    always_comb begin
        s1_live = s1_req && !((ZERO_REG != 0) && (s1_addr == '0));
        wmask   = '1;
    end
`endif

    always_comb begin
        dec_onehot = '0;
        if (s1_live) begin
            dec_onehot[s1_addr] = 1'b1;
        end
    end

    assign pend_valid = s1_live;
    assign pend_addr  = s1_addr;
    assign pend_data  = s1_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            wr_ack       <= 1'b0;
            commit_count <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (dec_onehot[r]) begin
                    regs[r] <= (regs[r] & ~wmask) | (s1_data & wmask);
                end
            end
            // Discarded requests still acknowledge, so every request sees exactly one pulse.
            wr_ack <= s1_req;
            if (s1_live) begin
                commit_count <= commit_count + 16'd1;
            end
        end
    end

    always_comb begin
        regs_sliced = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (!((ZERO_REG != 0) && (r == 0))) begin
                    regs_sliced[b*NUM_REGS + r] = regs[r][b];
                end
            end
        end
    end

endmodule

// File: doc/regfile_write_decoder.md
Name: regfile_write_decoder

Overview:
Write-side counterpart to the 32:1 bit-select mux tree used on register-file read ports.
- Accepts one register write request per cycle.
- Registers the request for one pipeline stage, then decodes the 5-bit address into a 32-bit one-hot write enable and commits the data into 32 storage words.
- Exposes storage bit-sliced, so each 32-bit group feeds one 32:1 read mux directly.
- Exposes the in-flight write, so read logic can forward it.

Parameters:
DATA_WIDTH, 32, width of each register word
ADDR_WIDTH, 5, address width; NUM_REGS = 2**ADDR_WIDTH = 32
ZERO_REG, 1, when 1, register 0 reads as zero and writes to it are discarded

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  write request valid this cycle
wr_addr  in  ADDR_WIDTH  destination register
wr_data  in  DATA_WIDTH  write data
dec_onehot  out  NUM_REGS  decoded write enable of the pending stage (combinational from stage regs)
pend_valid  out  1  a write is in flight (stage S1 holds a committable write)
pend_addr  out  ADDR_WIDTH  address of in-flight write
pend_data  out  DATA_WIDTH  data of in-flight write
wr_ack  out  1  one-cycle pulse, cycle after a request's commit edge
regs_sliced  out  NUM_REGS*DATA_WIDTH  bit b of register r at index b*NUM_REGS + r
commit_count  out  16  number of committed (non-discarded) writes

Behaviour:
- Reset (synchronous, active-high, sampled on rising clk):
  - All 32 registers cleared to 0.
  - S1 stage valid cleared; the in-flight write is discarded, not committed.
  - dec_onehot = 0, pend_valid = 0, pend_addr = 0, pend_data = 0.
  - wr_ack = 0, commit_count = 0.
- Stage S1 (edge E0): if wr_en, capture wr_addr/wr_data into S1 and set s1_req = 1; otherwise s1_req = 0.
- Discard rule: s1_live = s1_req AND NOT (ZERO_REG AND s1_addr == 0).
- Cycle after E0, from S1:
  - pend_valid = s1_live.
  - pend_addr/pend_data = S1 contents.
  - dec_onehot = s1_live ? (1 << s1_addr) : 0.
- Commit (edge E1 = E0+1): every register r with dec_onehot[r] = 1 loads s1_data; commit_count increments by 1 if s1_live.
- regs_sliced reflects new value from the cycle after E1. Write-to-visible latency = 2 edges.
- wr_ack = 1 in the cycle after E1 for every s1_req, including discarded r0 writes. This gives uniform per-request acknowledgement.
- Throughput: one write per cycle, no stalls, no ready signal. Back-to-back requests pipeline; S1 is overwritten each edge.
- Consecutive writes to the same address commit in order; the later value persists.
- wr_en = 0 cycles leave storage unchanged.
- dec_onehot is strictly one-hot or all-zero.
- commit_count wraps 0xFFFF -> 0x0000.
- ZERO_REG = 1: register 0 slice bits are constant 0. ZERO_REG = 0: register 0 is an ordinary register.
- X on wr_addr while wr_en = 0 must not affect state.

Optional Feature:
Macro REGFILE_BYTE_MASK_EN.
- Defined:
  - Adds input wr_be, width DATA_WIDTH/8, captured into S1 alongside the data.
  - At commit, only bytes whose wr_be bit is 1 are updated.
  - A request with wr_be = 0 still acks but does not commit and does not increment commit_count. pend_valid = 0 for it.
  - pend_data shows full captured data.
- Undefined: no wr_be port; all bytes are written on commit.

Test Plan:
- Reset, then idle 3 cycles -> all regs_sliced 0, dec_onehot 0, pend_valid 0, wr_ack 0, commit_count 0.
- wr_en=1, addr=5, data=0xDEADBEEF at edge 0:
  - cycle 1: dec_onehot = 0x00000020, pend_valid = 1.
  - cycle 2: wr_ack = 1, regs_sliced[b*32+5] = bit b of 0xDEADBEEF, commit_count = 1.
- Write addr=0, data=0xFFFFFFFF (ZERO_REG=1) -> dec_onehot stays 0, wr_ack pulses, register 0 slices stay 0, commit_count unchanged.
- Back-to-back writes r7=0x1, r7=0x2, r9=0x3 on consecutive edges -> final r7 = 0x2, r9 = 0x3, three consecutive wr_ack pulses, commit_count += 3.
- Write r3=0xAAAA5555, assert reset on the following edge -> r3 stays 0, no wr_ack, commit_count 0.
- REGFILE_BYTE_MASK_EN defined: r4 = 0x11223344 full mask, then data 0xFFFFFFFF with wr_be = 4'b0101 -> r4 = 0x11FF33FF. A further write with wr_be = 0 -> r4 unchanged, wr_ack pulses, commit_count unchanged.
